// File: rtl/merger_pkg.sv
// Shared merger definitions: lane FSM states, sentinel and clog2 helpers.
// Used by fiber_fetch_buffer and the radix-R merger.
package merger_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } fb_state_t;

    localparam int MAX_COORD_BITS = 64;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // All-ones of width w, zero-extended to MAX_COORD_BITS; callers slice.
    function automatic logic [MAX_COORD_BITS-1:0] sentinel(input int w);
        logic [MAX_COORD_BITS-1:0] s;
        s = '0;
        for (int i = 0; i < MAX_COORD_BITS; i++) begin
            if (i < w) begin
                s[i] = 1'b1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/fiber_fifo_mem.sv
// Coordinate storage for one merger lane.
// Registered write port, combinational read at the read pointer.
module fiber_fifo_mem
    import merger_pkg::*;
#(
    parameter int COORD_BITS = 32,
    parameter int DEPTH      = 4,
    localparam int PW        = clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  i_wr_en,
    input  logic [PW-1:0]         i_wr_ptr,
    input  logic [COORD_BITS-1:0] i_wr_data,
    input  logic [PW-1:0]         i_rd_ptr,
    output logic [COORD_BITS-1:0] o_rd_data
);

    logic [COORD_BITS-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_ptr];

endmodule

// File: rtl/fiber_fetch_buffer.sv
// Per-lane fiber buffer feeding the merger; presents SENTINEL when exhausted.
// Optional protocol checks: define FIBER_FETCH_BUFFER_CHECK_EN.
module fiber_fetch_buffer
    import merger_pkg::*;
#(
    parameter int COORD_BITS = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fiber_start,
    input  logic [COORD_BITS-1:0] in_coord,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [COORD_BITS-1:0] head_coord,
    output logic                  head_valid,
    input  logic                  fetch,
    output logic                  fiber_done,
    output logic                  err
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [PW-1:0] PTR_INC = PW'(1);
    localparam logic [MAX_COORD_BITS-1:0] SENT_W = sentinel(COORD_BITS);
    localparam logic [COORD_BITS-1:0] SENTINEL = SENT_W[COORD_BITS-1:0];

    fb_state_t       r_state;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_fiber_done;

    logic                  w_empty;
    logic                  w_idle;
    logic                  w_in_ready;
    logic                  w_head_valid;
    logic                  w_push;
    logic                  w_pop;
    logic [COORD_BITS-1:0] w_rd_data;

    assign w_idle       = (r_state == IDLE);
    assign w_empty      = (r_count == '0);
    assign w_in_ready   = (r_state == STREAM) && (r_count < FULL_C);
    assign w_head_valid = w_idle ? 1'b1 : !w_empty;
    assign w_push       = in_valid && w_in_ready;
    assign w_pop        = fetch && w_head_valid && !w_idle;

    fiber_fifo_mem #(
        .COORD_BITS (COORD_BITS),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clock      (clock),
        .i_wr_en    (w_push),
        .i_wr_ptr   (r_wr_ptr),
        .i_wr_data  (in_coord),
        .i_rd_ptr   (r_rd_ptr),
        .o_rd_data  (w_rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_fiber_done <= 1'b0;
        end else begin
            r_fiber_done <= 1'b0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_INC;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_INC;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase
            unique case (r_state)
                IDLE: begin
                    if (fiber_start) begin
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_push && in_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Nothing is pushed here, so a pop at count 1 empties it.
                    if (w_pop && (r_count == ONE_C)) begin
                        r_state      <= IDLE;
                        r_fiber_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign head_valid = w_head_valid;
    assign head_coord = (w_idle || w_empty) ? SENTINEL : w_rd_data;
    assign fiber_done = r_fiber_done;

`ifdef FIBER_FETCH_BUFFER_CHECK_EN
    logic                  r_err;
    logic                  r_first;
    logic [COORD_BITS-1:0] r_last_coord;
    logic                  w_err_set;

    assign w_err_set =
        (!w_idle && fetch && !w_head_valid) ||
        (w_push && (in_coord == SENTINEL)) ||
        (w_push && !r_first && (in_coord <= r_last_coord)) ||
        (fiber_start && !w_idle);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err        <= 1'b0;
            r_first      <= 1'b1;
            r_last_coord <= '0;
        end else begin
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_idle && fiber_start) begin
                r_first <= 1'b1;
            end
            if (w_push) begin
                r_last_coord <= in_coord;
                r_first      <= 1'b0;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fiber_fetch_buffer.sv
// Bench for fiber_fetch_buffer: directed steps plus random fibers
// checked against a queue-based lane model.
module tb_fiber_fetch_buffer;

    localparam int W = 32;
    localparam int D = 4;
    localparam logic [W-1:0] SENT = 32'hFFFF_FFFF;
`ifdef FIBER_FETCH_BUFFER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         fiber_start = 1'b0;
    logic [W-1:0] in_coord = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [W-1:0] head_coord;
    logic         head_valid;
    logic         fetch = 1'b0;
    logic         fiber_done;
    logic         err;

    always #5 clock = ~clock;

    fiber_fetch_buffer #(.COORD_BITS(W), .DEPTH(D)) dut (
        .clock       (clock),
        .reset       (reset),
        .fiber_start (fiber_start),
        .in_coord    (in_coord),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .head_coord  (head_coord),
        .head_valid  (head_valid),
        .fetch       (fetch),
        .fiber_done  (fiber_done),
        .err         (err)
    );

    int total = 0;
    int passed = 0;

    // Lane model: mode 0 idle, 1 accepting, 2 draining.
    int           m_mode = 0;
    logic [W-1:0] q[$];
    bit           m_done = 0;
    bit           m_err = 0;
    bit           m_first = 1;
    logic [W-1:0] m_last = '0;
    bit           g_pushed = 0;
    logic [W-1:0] pend[$];
    bit           rand_valid = 0;

    function automatic bit m_ready();
        return (m_mode == 1) && (q.size() < D);
    endfunction

    function automatic bit m_hv();
        return (m_mode == 0) ? 1'b1 : (q.size() != 0);
    endfunction

    function automatic logic [W-1:0] m_head();
        return (m_mode == 0 || q.size() == 0) ? SENT : q[0];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".in_ready"}, W'(in_ready), W'(m_ready()));
        chk({tag, ".head_valid"}, W'(head_valid), W'(m_hv()));
        chk({tag, ".head_coord"}, head_coord, m_head());
        chk({tag, ".fiber_done"}, W'(fiber_done), W'(m_done));
        chk({tag, ".err"}, W'(err), W'(m_err));
    endtask

    task automatic tick(input string tag);
        bit push, pop, e, st, lst, rs;
        int old_mode;
        logic [W-1:0] cd;
        old_mode = m_mode;
        push = in_valid && m_ready();
        pop  = fetch && m_hv() && (m_mode != 0);
        e = 0;
        if (CHK) begin
            if (m_mode != 0 && fetch && !m_hv()) e = 1;
            if (push && in_coord == SENT) e = 1;
            if (push && !m_first && in_coord <= m_last) e = 1;
            if (fiber_start && m_mode != 0) e = 1;
        end
        st = fiber_start; lst = in_last; cd = in_coord; rs = reset;
        @(posedge clock);
        #1;
        g_pushed = 0;
        if (rs) begin
            m_mode = 0; q.delete(); m_done = 0; m_err = 0; m_first = 1;
        end else begin
            m_done = 0;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(cd); m_last = cd; m_first = 0; g_pushed = 1;
            end
            if (e) m_err = 1;
            if (old_mode == 0 && st) begin
                m_mode = 1; m_first = 1;
            end else if (old_mode == 1 && push && lst) begin
                m_mode = 2;
            end else if (old_mode == 2 && pop && q.size() == 0) begin
                m_mode = 0; m_done = 1;
            end
        end
        check_outputs(tag);
    endtask

    task automatic feed_cycle(input string tag, input bit f);
        bit v;
        v = (pend.size() > 0) && (!rand_valid || ($urandom % 4 != 0));
        in_valid = v;
        in_coord = v ? pend[0] : W'($urandom);
        in_last  = v && (pend.size() == 1);
        fetch    = f;
        tick(tag);
        if (g_pushed) void'(pend.pop_front());
        in_valid = 0; in_last = 0; fetch = 0;
    endtask

    task automatic start_fiber(input string tag);
        fiber_start = 1;
        tick(tag);
        fiber_start = 0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1;
        tick(tag);
        reset = 0;
        pend.delete();
    endtask

    initial begin
        int n, dones;
        logic [W-1:0] c;

        // Reset held, then idle fetch is ignored.
        reset = 1;
        repeat (3) tick("t1_reset");
        reset = 0;
        fetch = 1;
        tick("t1_idle_fetch");
        fetch = 0;

        // Basic fiber 3, 7, 12.
        start_fiber("t2_start");
        pend = '{32'd3, 32'd7, 32'd12};
        dones = 0; n = 0;
        while ((m_mode != 0 || pend.size() > 0) && n < 50) begin
            feed_cycle("t2", m_hv());
            if (fiber_done) dones++;
            n++;
        end
        chk("t2_timeout", W'(n >= 50), '0);
        chk("t2_done_pulses", W'(dones), W'(1));
        tick("t2_after");

        // Fill, backpressure, then drain across pointer wrap.
        start_fiber("t3_start");
        pend = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        repeat (6) feed_cycle("t3_full", 1'b0);
        feed_cycle("t3_pop1", 1'b1);
        n = 0;
        while (m_mode != 0 && n < 50) begin
            feed_cycle("t3_drain", m_hv());
            n++;
        end
        chk("t3_timeout", W'(n >= 50), '0);

        // Simultaneous push and pop at occupancy 2.
        start_fiber("t4_start");
        for (int i = 0; i < 8; i++) pend.push_back(W'(100 + 10 * i));
        repeat (2) feed_cycle("t4_fill", 1'b0);
        repeat (6) feed_cycle("t4_pushpop", 1'b1);
        n = 0;
        while (m_mode != 0 && n < 50) begin
            feed_cycle("t4_drain", m_hv());
            n++;
        end
        chk("t4_timeout", W'(n >= 50), '0);

        // Reset in the middle of a fiber.
        start_fiber("t5_start");
        pend = '{32'd20, 32'd21, 32'd22, 32'd23};
        repeat (2) feed_cycle("t5_push", 1'b0);
        do_reset("t5_reset");
        repeat (3) tick("t5_idle");

        // Protocol errors: decreasing coordinate, then fetch on empty.
        start_fiber("t6_start");
        pend = '{32'd9, 32'd5, 32'd50};
        repeat (3) feed_cycle("t6_order", 1'b0);
        repeat (2) tick("t6_sticky");
        do_reset("t6_reset_a");
        start_fiber("t6_start_b");
        feed_cycle("t6_empty_fetch", 1'b1);
        tick("t6_sticky_b");
        do_reset("t6_reset_b");

        // Random fibers with strictly increasing coordinates.
        rand_valid = 1;
        for (int f = 0; f < 30; f++) begin
            start_fiber("rnd_start");
            c = W'($urandom_range(0, 1000));
            for (int k = 0; k < int'($urandom_range(1, 9)); k++) begin
                c = c + W'($urandom_range(1, 100));
                pend.push_back(c);
            end
            n = 0;
            while ((m_mode != 0 || pend.size() > 0) && n < 300) begin
                if ($urandom % 97 == 0) begin
                    do_reset("rnd_reset");
                end else begin
                    feed_cycle("rnd", m_hv() && ($urandom % 3 != 0));
                end
                n++;
            end
            chk("rnd_timeout", W'(n >= 300), '0);
            if ($urandom % 2 == 0) tick("rnd_gap");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
